// File: rtl/hid_event_pkg.sv
// Shared definitions for the HID event encoder:
// record opcodes, report types, record layout and FSM states.
package hid_event_pkg;

  localparam int REC_LEN = 4;

  localparam logic [7:0] REC_KEYDOWN = 8'h01;
  localparam logic [7:0] REC_KEYUP   = 8'h02;
  localparam logic [7:0] REC_REPEAT  = 8'h03;
  localparam logic [7:0] REC_MOUSE   = 8'h20;
  localparam logic [7:0] REC_GAMEPAD = 8'h30;

  localparam logic [1:0] USB_KBD     = 2'd1;
  localparam logic [1:0] USB_MOUSE   = 2'd2;
  localparam logic [1:0] USB_GAMEPAD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EMIT
  } state_t;

  // Element 0 is the first byte on the wire.
  typedef logic [REC_LEN-1:0][7:0] rec_t;

  function automatic rec_t key_rec(
    input logic [7:0] op,
    input logic [7:0] scan,
    input logic [7:0] m
  );
    rec_t r;
    r[0] = op;
    r[1] = scan;
    r[2] = m;
    r[3] = 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/hid_byte_fifo.sv
// Byte FIFO feeding the UART side; exposes its free-entry count
// so whole records can be admitted or refused up front.
module hid_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp, cnt;
  logic do_push, do_pop;

  assign cnt     = wp - rp;
  assign valid   = cnt != '0;
  assign free    = (AW+1)'(DEPTH) - cnt;
  assign do_push = push && (cnt != (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rp[AW-1:0]] : 8'h00;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hid_event_encoder.sv
// Turns USB HID reports into 4-byte event records
// (key down/up/repeat, mouse position, gamepad) on a byte stream.
module hid_event_encoder #(
  parameter int N_KEYS        = 6,
  parameter int FIFO_DEPTH    = 64,
  parameter int POS_W         = 10,
  parameter int REPEAT_DELAY  = 6000000,
  parameter int REPEAT_PERIOD = 1200000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            usb_type,
  input  logic                  usb_report,
  input  logic [7:0]            key_modifiers,
  input  logic [8*N_KEYS-1:0]   keys,
  input  logic [7:0]            mouse_btn,
  input  logic [7:0]            mouse_dx,
  input  logic [7:0]            mouse_dy,
  input  logic [9:0]            game_btns,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  import hid_event_pkg::*;

  localparam int IW = $clog2(2*N_KEYS+1);
  localparam int FW = $clog2(FIFO_DEPTH)+1;
  localparam logic [POS_W-1:0] POS_MAX = '1;

  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [1:0] bcnt;
  rec_t rec, rec_n, mouse_rec, gp_rec;
  logic wr_ok, ret_scan;
  logic [N_KEYS-1:0][7:0] new_keys, prev_keys;
  logic [7:0] mods;
  logic [POS_W-1:0] pos_x, pos_y, nx, ny;
  logic [11:0] x12, y12;
  logic [9:0] gp_last;
  logic [7:0] rep_code;
  logic rep_armed, rep_pend;
  logic [31:0] rep_cnt;
  logic [FW-1:0] free;
  logic [4:0] unused_btn;

  logic load_kbd, load_mouse, load_gp;
  logic start_emit, take_rep, scan_done;
  logic kd_event, ku_event, busy_hit, push;
  logic [7:0] code;
  logic in_new, in_prev;

  assign unused_btn = mouse_btn[7:3];

  function automatic logic [POS_W-1:0] clamp_add(
    input logic [POS_W-1:0] p,
    input logic [7:0]       d
  );
    logic signed [POS_W+1:0] s;
    s = $signed({2'b00, p})
      + $signed({{(POS_W-6){d[7]}}, d});
    if (s[POS_W+1])  return '0;
    else if (s[POS_W]) return POS_MAX;
    else return s[POS_W-1:0];
  endfunction

  function automatic logic [11:0] ext12(
    input logic [POS_W-1:0] p
  );
    logic [11:0] r;
    r = '0;
    r[POS_W-1:0] = p;
    return r;
  endfunction

  always_comb begin
    nx = clamp_add(pos_x, mouse_dx);
    ny = clamp_add(pos_y, mouse_dy);
    x12 = ext12(nx);
    y12 = ext12(ny);
    mouse_rec[0] = REC_MOUSE | {5'b0, mouse_btn[2:0]};
    mouse_rec[1] = x12[7:0];
    mouse_rec[2] = y12[7:0];
    mouse_rec[3] = {y12[11:8], x12[11:8]};
    gp_rec[0] = REC_GAMEPAD;
    gp_rec[1] = game_btns[9:2];
    gp_rec[2] = {6'b0, game_btns[1:0]};
    gp_rec[3] = 8'h00;
  end

  // Scan slot: indices below N_KEYS walk the new set,
  // the rest walk the previous set.
  always_comb begin
    code = 8'h00;
    in_new = 1'b0;
    in_prev = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (idx == IW'(i)) code = new_keys[i];
      if (idx == IW'(i + N_KEYS)) code = prev_keys[i];
    end
    for (int i = 0; i < N_KEYS; i++) begin
      in_new  = in_new  | (new_keys[i]  == code);
      in_prev = in_prev | (prev_keys[i] == code);
    end
  end

  always_comb begin
    state_n = state;
    rec_n = rec;
    load_kbd = 1'b0;
    load_mouse = 1'b0;
    load_gp = 1'b0;
    start_emit = 1'b0;
    take_rep = 1'b0;
    scan_done = 1'b0;
    kd_event = 1'b0;
    ku_event = 1'b0;
    push = 1'b0;
    busy_hit = usb_report && (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (usb_report) begin
          unique case (usb_type)
            USB_KBD: begin
              load_kbd = 1'b1;
              state_n = ST_SCAN;
            end
            USB_MOUSE: begin
              load_mouse = 1'b1;
              start_emit = 1'b1;
              rec_n = mouse_rec;
            end
            USB_GAMEPAD: begin
              if (game_btns != gp_last) begin
                load_gp = 1'b1;
                start_emit = 1'b1;
                rec_n = gp_rec;
              end
            end
            default: ;
          endcase
        end else if (rep_pend) begin
          take_rep = 1'b1;
          start_emit = 1'b1;
          rec_n = key_rec(REC_REPEAT, rep_code, mods);
        end
      end
      ST_SCAN: begin
        if (idx == IW'(2*N_KEYS)) begin
          scan_done = 1'b1;
          state_n = ST_IDLE;
        end else if (idx < IW'(N_KEYS)) begin
          if (code != 8'h00 && !in_prev) begin
            kd_event = 1'b1;
            start_emit = 1'b1;
            rec_n = key_rec(REC_KEYDOWN, code, mods);
          end
        end else if (code != 8'h00 && !in_new) begin
          ku_event = 1'b1;
          start_emit = 1'b1;
          rec_n = key_rec(REC_KEYUP, code, mods);
        end
      end
      ST_EMIT: begin
        push = wr_ok;
        if (bcnt == 2'd3)
          state_n = ret_scan ? ST_SCAN : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (start_emit) state_n = ST_EMIT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx <= '0;
      bcnt <= '0;
      rec <= '0;
      wr_ok <= 1'b0;
      ret_scan <= 1'b0;
      new_keys <= '0;
      prev_keys <= '0;
      mods <= '0;
      pos_x <= '0;
      pos_y <= '0;
      gp_last <= '0;
      rep_code <= '0;
      rep_armed <= 1'b0;
      rep_pend <= 1'b0;
      rep_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (load_kbd) begin
        new_keys <= keys;
        mods <= key_modifiers;
        idx <= '0;
      end else if (state == ST_SCAN && !scan_done) begin
        idx <= idx + 1'b1;
      end
      if (scan_done) prev_keys <= new_keys;
      if (load_mouse) begin
        pos_x <= nx;
        pos_y <= ny;
      end
      if (load_gp) gp_last <= game_btns;
      // Admission is decided once, so a record is all-or-nothing.
      if (start_emit) begin
        rec <= rec_n;
        wr_ok <= free >= FW'(REC_LEN);
        ret_scan <= state == ST_SCAN;
        bcnt <= '0;
      end else if (state == ST_EMIT) begin
        bcnt <= bcnt + 1'b1;
      end
      if ((start_emit && free < FW'(REC_LEN)) || busy_hit)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
      if (take_rep) rep_pend <= 1'b0;
      if (rep_armed) begin
        if (rep_cnt == '0) begin
          rep_pend <= 1'b1;
          rep_cnt <= 32'(REPEAT_PERIOD - 1);
        end else begin
          rep_cnt <= rep_cnt - 1'b1;
        end
      end
      if (ku_event && code == rep_code) begin
        rep_armed <= 1'b0;
        rep_pend <= 1'b0;
      end
      if (kd_event) begin
        rep_armed <= 1'b1;
        rep_pend <= 1'b0;
        rep_code <= code;
        rep_cnt <= 32'(REPEAT_DELAY - 1);
      end
    end
  end

  hid_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(push),
    .din(rec[bcnt]),
    .pop(out_ready),
    .dout(out_data),
    .valid(out_valid),
    .free(free)
  );

endmodule

// File: tb/tb_hid_event_encoder.sv
// Directed bench for hid_event_encoder with a byte scoreboard
// and a monitor that pops expected bytes on every handshake.
module tb_hid_event_encoder;

  localparam int N_KEYS = 6;
  localparam int DEPTH  = 64;
  localparam int POS_W  = 10;
  localparam int RD     = 100;
  localparam int RP     = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] usb_type = '0;
  logic usb_report = 1'b0;
  logic [7:0] key_modifiers = '0;
  logic [8*N_KEYS-1:0] keys = '0;
  logic [7:0] mouse_btn = '0;
  logic [7:0] mouse_dx = '0;
  logic [7:0] mouse_dy = '0;
  logic [9:0] game_btns = '0;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic overflow;
  logic ovf_clr = 1'b0;

  logic [7:0] exp_q[$];
  int rep_t[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_kd = 0;
  int rec_pos = 0;
  int px = 0;
  int py = 0;

  hid_event_encoder #(
    .N_KEYS(N_KEYS),
    .FIFO_DEPTH(DEPTH),
    .POS_W(POS_W),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .usb_type(usb_type),
    .usb_report(usb_report),
    .key_modifiers(key_modifiers),
    .keys(keys),
    .mouse_btn(mouse_btn),
    .mouse_dx(mouse_dx),
    .mouse_dy(mouse_dy),
    .game_btns(game_btns),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_rng(
    input string tag,
    input int v,
    input int lo,
    input int hi
  );
    n_cmp++;
    assert (v >= lo && v <= hi) else begin
      n_err++;
      $error("FAIL %s got=%0d want=%0d..%0d", tag, v, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] want;
    if (!resetn) begin
      rec_pos = 0;
    end else if (out_valid && out_ready) begin
      if (rec_pos == 0) begin
        if (out_data == 8'h01) last_kd = cyc;
        if (out_data == 8'h03) rep_t.push_back(cyc);
      end
      rec_pos = (rec_pos + 1) % 4;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL extra_byte got=%0h want=none", out_data);
      end else begin
        want = exp_q.pop_front();
        check("byte", {24'h0, out_data}, {24'h0, want});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic expk(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(8'h00);
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > (1 << POS_W) - 1) return (1 << POS_W) - 1;
    return v;
  endfunction

  task automatic send_kbd(
    input logic [7:0] m,
    input logic [7:0] k0,
    input logic [7:0] k1
  );
    usb_type = 2'd1;
    key_modifiers = m;
    keys = '0;
    keys[7:0] = k0;
    keys[15:8] = k1;
    usb_report = 1'b1;
    tick();
    usb_report = 1'b0;
  endtask

  task automatic send_mouse(
    input logic [2:0] b,
    input int dx,
    input int dy,
    input bit keep
  );
    px = clampi(px + dx);
    py = clampi(py + dy);
    if (keep) begin
      exp_q.push_back(8'h20 | {5'b0, b});
      exp_q.push_back(8'(px));
      exp_q.push_back(8'(py));
      exp_q.push_back(8'((((py >> 8) & 15) << 4) | ((px >> 8) & 15)));
    end
    usb_type = 2'd2;
    mouse_btn = {5'b0, b};
    mouse_dx = 8'(dx);
    mouse_dy = 8'(dy);
    usb_report = 1'b1;
    tick();
    usb_report = 1'b0;
  endtask

  task automatic send_gp(input logic [9:0] g, input bit keep);
    if (keep) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(g[9:2]);
      exp_q.push_back({6'b0, g[1:0]});
      exp_q.push_back(8'h00);
    end
    usb_type = 2'd3;
    game_btns = g;
    usb_report = 1'b1;
    tick();
    usb_report = 1'b0;
  endtask

  initial begin
    settle(3);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    resetn = 1'b1;
    tick();
    out_ready = 1'b1;

    expk(8'h01, 8'h04, 8'h00);
    send_kbd(8'h00, 8'h04, 8'h00);
    drain(60);
    settle(16);
    expk(8'h01, 8'h05, 8'h02);
    send_kbd(8'h02, 8'h04, 8'h05);
    drain(60);
    settle(16);
    expk(8'h02, 8'h04, 8'h02);
    expk(8'h02, 8'h05, 8'h02);
    send_kbd(8'h02, 8'h00, 8'h00);
    drain(60);
    settle(16);

    for (int i = 0; i < 8; i++) begin
      send_mouse(3'd0, 127, -5, 1'b1);
      drain(40);
      settle(2);
    end
    send_mouse(3'd0, 4, -5, 1'b1);
    drain(40);
    settle(2);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h03);
    send_mouse(3'd1, 10, -5, 1'b0);
    drain(40);
    settle(2);
    send_mouse(3'd2, -128, 50, 1'b1);
    drain(40);
    settle(2);

    send_gp(10'h200, 1'b1);
    drain(40);
    settle(2);
    send_gp(10'h200, 1'b0);
    settle(12);
    send_gp(10'h3FF, 1'b1);
    drain(40);
    settle(2);

    rep_t.delete();
    expk(8'h01, 8'h04, 8'h00);
    expk(8'h03, 8'h04, 8'h00);
    expk(8'h03, 8'h04, 8'h00);
    send_kbd(8'h00, 8'h04, 8'h00);
    drain(400);
    expk(8'h02, 8'h04, 8'h00);
    send_kbd(8'h00, 8'h00, 8'h00);
    drain(60);
    settle(150);
    check("rep_count", rep_t.size(), 2);
    if (rep_t.size() >= 2) begin
      check_rng("rep_first", rep_t[0] - last_kd, RD - 3, RD + 5);
      check_rng("rep_period", rep_t[1] - rep_t[0], RP - 2, RP + 2);
    end

    check("ovf_idle", overflow, 0);
    send_kbd(8'h00, 8'h00, 8'h00);
    usb_type = 2'd3;
    game_btns = 10'h155;
    usb_report = 1'b1;
    ovf_clr = 1'b1;
    tick();
    usb_report = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_busy_vs_clr", overflow, 1);
    settle(20);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    send_gp(10'h155, 1'b1);
    drain(40);
    settle(2);

    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_mouse(3'd0, -1, 1, i < 16);
      settle(8);
      if (i == 0) begin
        check("hold_valid", out_valid, 1);
        check("hold_data0", out_data, exp_q[0]);
      end
      if (i == 10) check("hold_data1", out_data, exp_q[0]);
      if (i == 15) check("full_no_ovf", overflow, 0);
    end
    check("full_ovf", overflow, 1);
    out_ready = 1'b1;
    drain(200);
    settle(2);
    send_mouse(3'd4, -1, 1, 1'b1);
    drain(40);
    settle(2);

    out_ready = 1'b0;
    send_mouse(3'd0, 3, 3, 1'b0);
    settle(2);
    check("mid_emit_valid", out_valid, 1);
    resetn = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    check("async_ovf", overflow, 0);
    px = 0;
    py = 0;
    settle(2);
    resetn = 1'b1;
    tick();
    out_ready = 1'b1;
    send_mouse(3'd2, 5, 7, 1'b1);
    drain(40);
    settle(2);
    send_gp(10'h000, 1'b0);
    settle(12);

    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
